// File: rtl/load_store_unit_if.sv
// Bundle of execute-stage request, writeback response, exception and mem_mgr
// port signals for the load/store unit; slave is the LSU side.
interface load_store_unit_if #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5
);
  logic                req_valid;
  logic                req_ready;
  logic                req_load;
  logic [WIDTH-1:0]    req_addr;
  logic [2:0]          req_bytes;
  logic                req_unsigned;
  logic [WIDTH-1:0]    req_wdata;
  logic [REG_ADDR-1:0] req_rd;

  logic [WIDTH-1:0]    mem_wr_addr;
  logic                mem_we;
  logic [2:0]          mem_wr_bytes;
  logic [WIDTH-1:0]    mem_wr_data;
  logic [WIDTH-1:0]    mem_rd_addr;
  logic                mem_re;
  logic [2:0]          mem_rd_bytes;
  logic                mem_rd_unsigned;
  logic [WIDTH-1:0]    mem_rd_data;

  logic                resp_valid;
  logic                resp_ready;
  logic [REG_ADDR-1:0] resp_rd;
  logic [WIDTH-1:0]    resp_data;

  logic                exc_valid;
  logic [1:0]          exc_cause;
  logic [WIDTH-1:0]    exc_addr;
  logic                exc_ack;

  modport slave (
    input  req_valid, req_load, req_addr, req_bytes, req_unsigned, req_wdata, req_rd,
    output req_ready,
    output mem_wr_addr, mem_we, mem_wr_bytes, mem_wr_data,
    output mem_rd_addr, mem_re, mem_rd_bytes, mem_rd_unsigned,
    input  mem_rd_data,
    output resp_valid, resp_rd, resp_data,
    input  resp_ready,
    output exc_valid, exc_cause, exc_addr,
    input  exc_ack
  );

  modport master (
    output req_valid, req_load, req_addr, req_bytes, req_unsigned, req_wdata, req_rd,
    input  req_ready,
    input  mem_wr_addr, mem_we, mem_wr_bytes, mem_wr_data,
    input  mem_rd_addr, mem_re, mem_rd_bytes, mem_rd_unsigned,
    output mem_rd_data,
    input  resp_valid, resp_rd, resp_data,
    output resp_ready,
    input  exc_valid, exc_cause, exc_addr,
    output exc_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator: checks size/alignment, issues to mem_mgr, returns load
// results over a response handshake and holds faults until acknowledged.
module load_store_unit #(
  parameter int WIDTH    = 32,
  parameter int BYTES    = WIDTH / 8,
  parameter int REG_ADDR = 5
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  localparam logic [2:0] MAX_CODE = 3'($clog2(BYTES));

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2,
    EXC       = 2'd3
  } state_t;

  state_t state, next_state;

  logic             size_ok;
  logic             aligned;
  logic             legal;
  logic             accept;
  logic [WIDTH-1:0] align_mask;
  logic [1:0]       fault_cause;

  assign size_ok     = bus.req_bytes <= MAX_CODE;
  assign align_mask  = (WIDTH'(1) << bus.req_bytes) - WIDTH'(1);
  assign aligned     = (bus.req_addr & align_mask) == '0;
  assign legal       = size_ok && aligned;
  assign accept      = bus.req_valid && bus.req_ready;
  // Illegal size outranks misalignment when both apply
  assign fault_cause = !size_ok ? 2'd2 : (bus.req_load ? 2'd0 : 2'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state          = state;
    bus.req_ready       = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_wr_addr     = '0;
    bus.mem_wr_bytes    = '0;
    bus.mem_wr_data     = '0;
    bus.mem_re          = 1'b0;
    bus.mem_rd_addr     = '0;
    bus.mem_rd_bytes    = '0;
    bus.mem_rd_unsigned = 1'b0;
    bus.resp_valid      = 1'b0;
    bus.exc_valid       = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so the request port closes the instant reset rises
        bus.req_ready = !rst;
        if (accept) begin
          if (!legal) begin
            next_state = EXC;
          end else if (bus.req_load) begin
            bus.mem_re          = 1'b1;
            bus.mem_rd_addr     = bus.req_addr;
            bus.mem_rd_bytes    = bus.req_bytes;
            bus.mem_rd_unsigned = bus.req_unsigned;
            next_state          = LOAD_WAIT;
          end else begin
            bus.mem_we       = 1'b1;
            bus.mem_wr_addr  = bus.req_addr;
            bus.mem_wr_bytes = bus.req_bytes;
            bus.mem_wr_data  = bus.req_wdata;
          end
        end
      end
      LOAD_WAIT: next_state = RESP;
      RESP: begin
        bus.resp_valid = !rst;
        if (bus.resp_ready) next_state = IDLE;
      end
      EXC: begin
        bus.exc_valid = !rst;
        if (bus.exc_ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Destination is latched at issue so the requester may move on immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp_rd   <= '0;
      bus.resp_data <= '0;
      bus.exc_cause <= '0;
      bus.exc_addr  <= '0;
    end else begin
      if (accept && legal && bus.req_load) bus.resp_rd <= bus.req_rd;
      if (state == LOAD_WAIT) bus.resp_data <= bus.mem_rd_data;
      if (accept && !legal) begin
        bus.exc_cause <= fault_cause;
        bus.exc_addr  <= bus.req_addr;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with queue scoreboards for memory
// strobes, load responses and exceptions, checked by a negedge monitor.
module tb_load_store_unit;

  localparam int WIDTH    = 32;
  localparam int REG_ADDR = 5;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  bytes;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  bytes;
    logic        uns;
  } rd_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic [1:0]  cause;
    logic [31:0] addr;
  } exc_t;

  wr_t   wr_q[$];
  rd_t   rd_q[$];
  resp_t resp_q[$];
  exc_t  exc_q[$];

  load_store_unit_if #(.WIDTH(WIDTH), .REG_ADDR(REG_ADDR)) bus ();

  load_store_unit #(.WIDTH(WIDTH), .REG_ADDR(REG_ADDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog act=timeout req=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s act=0x%08h req=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe/handshake must match the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we && bus.mem_re) checkOutput("we_re_exclusive", 32'd1, 32'd0);
      if (bus.mem_we) begin
        if (wr_q.size() == 0) checkOutput("unexpected_we", 32'd1, 32'd0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          checkOutput("wr_addr", bus.mem_wr_addr, w.addr);
          checkOutput("wr_bytes", 32'(bus.mem_wr_bytes), 32'(w.bytes));
          checkOutput("wr_data", bus.mem_wr_data, w.data);
        end
      end
      if (bus.mem_re) begin
        if (rd_q.size() == 0) checkOutput("unexpected_re", 32'd1, 32'd0);
        else begin
          rd_t r;
          r = rd_q.pop_front();
          checkOutput("rd_addr", bus.mem_rd_addr, r.addr);
          checkOutput("rd_bytes", 32'(bus.mem_rd_bytes), 32'(r.bytes));
          checkOutput("rd_unsigned", 32'(bus.mem_rd_unsigned), 32'(r.uns));
        end
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (resp_q.size() == 0) checkOutput("unexpected_resp", 32'd1, 32'd0);
        else begin
          resp_t p;
          p = resp_q.pop_front();
          checkOutput("resp_rd", 32'(bus.resp_rd), 32'(p.rd));
          checkOutput("resp_data", bus.resp_data, p.data);
        end
      end
      if (bus.exc_valid && bus.exc_ack) begin
        if (exc_q.size() == 0) checkOutput("unexpected_exc", 32'd1, 32'd0);
        else begin
          exc_t e;
          e = exc_q.pop_front();
          checkOutput("exc_cause", 32'(bus.exc_cause), 32'(e.cause));
          checkOutput("exc_addr", bus.exc_addr, e.addr);
        end
      end
    end
  end

  task automatic applyStimulus(input logic load, input logic [31:0] addr, input logic [2:0] bytes,
                               input logic uns, input logic [31:0] wdata, input logic [4:0] rd);
    bus.req_valid    = 1'b1;
    bus.req_load     = load;
    bus.req_addr     = addr;
    bus.req_bytes    = bytes;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    bus.req_rd       = rd;
  endtask

  task automatic idle_req();
    bus.req_valid = 1'b0;
    bus.req_load  = 1'b0;
    bus.req_addr  = '0;
    bus.req_bytes = '0;
    bus.req_wdata = '0;
    bus.req_rd    = '0;
  endtask

  // Store issued at posedge+1; leaves the request asserted for chaining
  task automatic do_store(input logic [31:0] addr, input logic [2:0] bytes, input logic [31:0] data);
    wr_t w;
    w.addr = addr; w.bytes = bytes; w.data = data;
    wr_q.push_back(w);
    applyStimulus(1'b0, addr, bytes, 1'b0, data, 5'd0);
    @(negedge clk);
    checkOutput("store_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("store_we", 32'(bus.mem_we), 32'd1);
    checkOutput("store_no_resp", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] bytes, input logic uns,
                         input logic [4:0] rd, input logic [31:0] mdata, input int hold);
    rd_t   r;
    resp_t p;
    r.addr = addr; r.bytes = bytes; r.uns = uns;
    p.rd = rd; p.data = mdata;
    rd_q.push_back(r);
    resp_q.push_back(p);
    applyStimulus(1'b1, addr, bytes, uns, 32'h0, rd);
    @(negedge clk);
    checkOutput("load_re_T", 32'(bus.mem_re), 32'd1);
    @(posedge clk); #1;
    idle_req();
    bus.mem_rd_data = mdata;
    @(negedge clk);
    checkOutput("load_re_T1", 32'(bus.mem_re), 32'd0);
    checkOutput("load_ready_T1", 32'(bus.req_ready), 32'd0);
    checkOutput("load_valid_T1", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    bus.mem_rd_data = 32'h12345678;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(bus.resp_valid), 32'd1);
      checkOutput("hold_data", bus.resp_data, mdata);
      checkOutput("hold_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      bus.mem_rd_data = ~bus.mem_rd_data;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("resp_valid_T2", 32'(bus.resp_valid), 32'd1);
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    checkOutput("after_resp_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("after_resp_valid", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic do_bad(input logic load, input logic [31:0] addr, input logic [2:0] bytes,
                        input logic [1:0] cause);
    exc_t e;
    e.cause = cause; e.addr = addr;
    exc_q.push_back(e);
    applyStimulus(load, addr, bytes, 1'b0, 32'hA5A5A5A5, 5'd9);
    @(negedge clk);
    checkOutput("bad_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("bad_we", 32'(bus.mem_we), 32'd0);
    checkOutput("bad_re", 32'(bus.mem_re), 32'd0);
    checkOutput("bad_exc_early", 32'(bus.exc_valid), 32'd0);
    @(posedge clk); #1;
    idle_req();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("exc_held", 32'(bus.exc_valid), 32'd1);
      checkOutput("exc_cause_held", 32'(bus.exc_cause), 32'(cause));
      checkOutput("exc_ready_low", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.exc_ack = 1'b1;
    @(posedge clk); #1;
    bus.exc_ack = 1'b0;
    @(negedge clk);
    checkOutput("exc_cleared", 32'(bus.exc_valid), 32'd0);
    checkOutput("exc_idle_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_req();
    bus.req_unsigned = 1'b0;
    bus.mem_rd_data  = '0;
    bus.resp_ready   = 1'b0;
    bus.exc_ack      = 1'b0;
    #2;
    applyStimulus(1'b0, 32'h20, 3'd2, 1'b0, 32'h11111111, 5'd0);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_re", 32'(bus.mem_re), 32'd0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_exc_valid", 32'(bus.exc_valid), 32'd0);
    checkOutput("rst_exc_cause", 32'(bus.exc_cause), 32'd0);
    checkOutput("rst_resp_data", bus.resp_data, 32'd0);
    checkOutput("rst_resp_rd", 32'(bus.resp_rd), 32'd0);
    checkOutput("rst_exc_addr", bus.exc_addr, 32'd0);
    idle_req();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single store");
    do_store(32'h10, 3'd2, 32'hDEADBEEF);
    idle_req();
    @(negedge clk);
    checkOutput("store_idle_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("store_idle_resp", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;

    $display("[TB] signed byte load");
    do_load(32'h13, 3'd0, 1'b0, 5'd5, 32'hFFFFFFDE, 0);
    @(posedge clk); #1;
    $display("[TB] load with stalled writeback");
    do_load(32'h13, 3'd0, 1'b0, 5'd5, 32'hFFFFFFDE, 3);
    @(posedge clk); #1;
    do_load(32'h24, 3'd2, 1'b1, 5'd31, 32'hCAFEF00D, 1);
    @(posedge clk); #1;

    $display("[TB] faults");
    bus.exc_ack = 1'b1;
    @(negedge clk);
    checkOutput("ack_idle_ignored", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.exc_ack = 1'b0;
    do_bad(1'b1, 32'h102, 3'd2, 2'd0);
    @(posedge clk); #1;
    do_bad(1'b0, 32'h101, 3'd1, 2'd1);
    @(posedge clk); #1;
    do_bad(1'b1, 32'h40, 3'd3, 2'd2);
    @(posedge clk); #1;
    do_bad(1'b0, 32'h3, 3'd4, 2'd2);
    @(posedge clk); #1;

    $display("[TB] async reset in LOAD_WAIT");
    begin
      rd_t r;
      r.addr = 32'h8; r.bytes = 3'd2; r.uns = 1'b0;
      rd_q.push_back(r);
    end
    applyStimulus(1'b1, 32'h8, 3'd2, 1'b0, 32'h0, 5'd7);
    @(posedge clk); #1;
    idle_req();
    bus.mem_rd_data = 32'hBADBAD00;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("async_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("async_resp_rd", 32'(bus.resp_rd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("post_rst_resp", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("post_rst_resp2", 32'(bus.resp_valid), 32'd0);
    checkOutput("post_rst_data", bus.resp_data, 32'd0);
    bus.resp_ready = 1'b0;
    @(posedge clk); #1;

    $display("[TB] back-to-back stores");
    for (int i = 0; i < 4; i++) do_store(32'(i * 4), 3'd2, 32'hA0000000 + 32'(i));
    idle_req();
    @(negedge clk);
    checkOutput("b2b_end_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    checkOutput("wr_q_empty", 32'(wr_q.size()), 32'd0);
    checkOutput("rd_q_empty", 32'(rd_q.size()), 32'd0);
    checkOutput("resp_q_empty", 32'(resp_q.size()), 32'd0);
    checkOutput("exc_q_empty", 32'(exc_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
